// File: rtl/window_3x3_generator_pkg.sv
// window_3x3_generator_pkg: shared frame geometry defaults and FSM state encoding
package window_3x3_generator_pkg;
    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;
    localparam int DEF_PIX_W      = 24;
    typedef enum logic [1:0] {STREAM, FLUSH, DONE} state_t;
endpackage

// File: rtl/window_line_buffer.sv
// window_line_buffer: single-port DEPTH x WIDTH RAM, synchronous read-before-write
module window_line_buffer
    import window_3x3_generator_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int WIDTH = DEF_PIX_W,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (en) begin
            rdata <= mem[addr];
            if (we) mem[addr] <= wdata;
        end
endmodule

// File: rtl/window_3x3_generator.sv
// window_3x3_generator: raster RGB stream to edge-replicated 3x3 windows, one per pixel
module window_3x3_generator
    import window_3x3_generator_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_W      = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel_1,
    output logic [PIX_W-1:0] out_pixel_2,
    output logic [PIX_W-1:0] out_pixel_3,
    output logic [PIX_W-1:0] out_pixel_4,
    output logic [PIX_W-1:0] out_pixel_5,
    output logic [PIX_W-1:0] out_pixel_6,
    output logic [PIX_W-1:0] out_pixel_7,
    output logic [PIX_W-1:0] out_pixel_8,
    output logic [PIX_W-1:0] out_pixel_9,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);
    localparam logic H_ODD = (IMG_HEIGHT % 2) == 1;

    state_t state, state_nx;
    logic [CW-1:0] col, addr;
    logic [RW-1:0] row;
    logic [FW-1:0] fcnt;
    logic accept, flushing, step, emit;
    logic st_valid, st_edge, st_first, st_top_rep, st_flush, st_sel;
    logic [PIX_W-1:0] st_pix, rd0, rd1, top, mid;
    logic [2:0][PIX_W-1:0] s0, s1, nc, lc, rc;

    assign in_ready = state == STREAM;
    assign flushing = state == FLUSH;
    assign accept   = in_valid && in_ready;
    assign step     = accept || flushing;
    assign addr     = flushing ? fcnt[CW-1:0] : col;
    assign emit     = flushing || (col != '0 && row != '0) || (col == '0 && row > RW'(1));

    always_comb begin
        state_nx = state;
        if (state == STREAM && accept && col == COL_LAST && row == ROW_LAST) state_nx = FLUSH;
        if (state == FLUSH && fcnt == FLUSH_LAST) state_nx = DONE;
        if (state == DONE) state_nx = STREAM;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= STREAM;
            col        <= '0;
            row        <= '0;
            fcnt       <= '0;
            st_valid   <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            st_edge    <= 1'b0;
            st_first   <= 1'b0;
            st_top_rep <= 1'b0;
            st_flush   <= 1'b0;
            st_sel     <= 1'b0;
            st_pix     <= '0;
        end else begin
            state      <= state_nx;
            st_valid   <= step;
            out_valid  <= step && emit;
            frame_done <= state == DONE;
            fcnt       <= flushing ? fcnt + 1'b1 : '0;
            if (accept) begin
                col <= col == COL_LAST ? '0 : col + 1'b1;
                if (col == COL_LAST) row <= row == ROW_LAST ? '0 : row + 1'b1;
            end
            // flush cycle k behaves like an accept of virtual pixel (H, k)
            if (step) begin
                st_edge    <= flushing ? (fcnt == '0 || fcnt == FLUSH_LAST) : col == '0;
                st_first   <= flushing ? fcnt == FW'(1) : col == CW'(1);
                st_top_rep <= !flushing && row == RW'(1);
                st_flush   <= flushing;
                st_sel     <= flushing ? H_ODD : row[0];
                st_pix     <= in_pixel;
            end
        end

    // rows ping-pong by parity: RAM[row%2] holds row r-2 until overwritten by row r
    window_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .en(step), .we(accept && !row[0]), .addr(addr), .wdata(in_pixel), .rdata(rd0)
    );
    window_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .en(step), .we(accept && row[0]), .addr(addr), .wdata(in_pixel), .rdata(rd1)
    );

    assign top = st_sel ? rd1 : rd0;
    assign mid = st_sel ? rd0 : rd1;
    assign nc  = {st_top_rep ? mid : top, mid, st_flush ? mid : st_pix};
    assign lc  = st_first ? s1 : s0;
    assign rc  = st_edge ? s1 : nc;

    always_ff @(posedge clk)
        if (st_valid) begin
            s0 <= s1;
            s1 <= nc;
        end

    assign out_pixel_1 = out_valid ? lc[2] : '0;
    assign out_pixel_2 = out_valid ? s1[2] : '0;
    assign out_pixel_3 = out_valid ? rc[2] : '0;
    assign out_pixel_4 = out_valid ? lc[1] : '0;
    assign out_pixel_5 = out_valid ? s1[1] : '0;
    assign out_pixel_6 = out_valid ? rc[1] : '0;
    assign out_pixel_7 = out_valid ? lc[0] : '0;
    assign out_pixel_8 = out_valid ? s1[0] : '0;
    assign out_pixel_9 = out_valid ? rc[0] : '0;
endmodule

// File: tb/tb_window_3x3_generator.sv
// tb_window_3x3_generator: scoreboard bench for the 3x3 window generator on a 4x4 image
module tb_window_3x3_generator;
    localparam int W = 4;
    localparam int H = 4;

    typedef struct { logic [215:0] win; int cyc; } exp_t;
    typedef struct { int gap; int frames; int rst_after; int exp_win; int exp_done; } scen_t;

    logic clk = 0, rst = 0, in_valid = 0;
    logic in_ready, out_valid, frame_done;
    logic [23:0] in_pixel = '0;
    logic [23:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [215:0] dout;
    exp_t q[$];
    exp_t e;
    logic [215:0] got[$];
    int cyc = 0, n_pass = 0, n_total = 0, n_win = 0, n_done = 0, last_out = 0;
    scen_t tbl[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign dout = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

    window_3x3_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_pixel_1(p1), .out_pixel_2(p2), .out_pixel_3(p3),
        .out_pixel_4(p4), .out_pixel_5(p5), .out_pixel_6(p6), .out_pixel_7(p7),
        .out_pixel_8(p8), .out_pixel_9(p9), .frame_done(frame_done)
    );

    task automatic check_w(input string nm, input logic [215:0] act, input logic [215:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_b(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    function automatic int clamp(input int v, input int n);
        return v < 0 ? 0 : (v >= n ? n - 1 : v);
    endfunction

    function automatic logic [23:0] pix(input int off, input int r, input int c);
        logic [7:0] b;
        b = 8'(16 * r + c + off);
        return {b, b, b};
    endfunction

    // reference window centred on (r,c) with edge replication, p1 in the MSBs
    function automatic logic [215:0] win(input int off, input int r, input int c);
        logic [215:0] w;
        w = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                w = {w[191:0], pix(off, clamp(r + dr, H), clamp(c + dc, W))};
        return w;
    endfunction

    function automatic logic [215:0] w9(input logic [71:0] b);
        logic [215:0] w;
        w = '0;
        for (int i = 8; i >= 0; i--) w = {w[191:0], {3{b[i*8 +: 8]}}};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int c, input int off);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pixel = pix(off, r, c);
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check_b("in_ready timeout", in_ready, 1'b1);
        else begin
            if (r >= 1 && c >= 1) q.push_back('{win(off, r - 1, c - 1), cyc + 1});
            if (r >= 2 && c == 0) q.push_back('{win(off, r - 2, W - 1), cyc + 1});
            if (r == H - 1 && c == W - 1)
                for (int j = 0; j <= W; j++)
                    q.push_back('{j == 0 ? win(off, H - 2, W - 1) : win(off, H - 1, j - 1), cyc + 2 + j});
        end
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk)
        if (rst) begin
            if (out_valid) begin
                n_win++;
                last_out = cyc;
                got.push_back(dout);
                if (q.size() == 0) check_i("unexpected window", 1, 0);
                else begin
                    e = q.pop_front();
                    check_w("window", dout, e.win);
                    check_i("window latency", cyc, e.cyc);
                end
            end
            if (frame_done) begin
                n_done++;
                check_i("frame_done after last window", cyc, last_out + 1);
                check_i("queue drained at frame_done", q.size(), 0);
            end
        end

    initial begin
        tbl[0] = '{0, 1, -1, 16, 1};
        tbl[1] = '{1, 1, -1, 16, 1};
        tbl[2] = '{0, 2, -1, 32, 2};
        tbl[3] = '{0, 1, 7, 16, 1};
        tbl[4] = '{2, 1, -1, 16, 1};
        tick();
        tick();
        check_b("reset out_valid", out_valid, 1'b0);
        check_b("reset in_ready", in_ready, 1'b1);
        check_b("reset frame_done", frame_done, 1'b0);
        check_w("reset window", dout, '0);
        rst = 1'b1;
        tick();
        for (int s = 0; s < 5; s++) begin
            q.delete();
            got.delete();
            n_win = 0;
            n_done = 0;
            if (tbl[s].rst_after > 0) begin
                for (int i = 0; i < tbl[s].rst_after; i++) send(i / W, i % W, 0);
                tick();
                tick();
                rst = 1'b0;
                #1;
                check_b("mid-frame reset out_valid", out_valid, 1'b0);
                check_b("mid-frame reset in_ready", in_ready, 1'b1);
                tick();
                rst = 1'b1;
                tick();
                q.delete();
                got.delete();
                n_win = 0;
                n_done = 0;
            end
            for (int f = 0; f < tbl[s].frames; f++)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++) begin
                        send(r, c, f * 128);
                        if (r == H - 1 && c == W - 1)
                            for (int k = 0; k < 5; k++) begin
                                check_b("in_ready low after last pixel", in_ready, 1'b0);
                                tick();
                            end
                        else if (tbl[s].gap == 1) tick();
                        else if (tbl[s].gap == 2) repeat ($urandom_range(2, 0)) tick();
                    end
            for (int i = 0; i < 60 && n_done < tbl[s].frames; i++) tick();
            tick();
            check_i("window count", n_win, tbl[s].exp_win);
            check_i("frame_done count", n_done, tbl[s].exp_done);
            check_i("scoreboard empty", q.size(), 0);
            check_b("in_ready back high", in_ready, 1'b1);
            if (s == 0) begin
                if (got.size() != 16) check_i("window log size", got.size(), 16);
                else begin
                    check_w("first window", got[0], w9(72'h00_00_01_00_00_01_10_10_11));
                    check_w("window centre (2,3)", got[11], w9(72'h12_13_13_22_23_23_32_33_33));
                    check_w("last window", got[15], w9(72'h22_23_23_32_33_33_32_33_33));
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
